// File: rtl/bin_to_bcd_pkg.sv
// Shared types and default sizing for the binary-to-BCD converter.
package bin_to_bcd_pkg;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_DIGITS = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage : bin_to_bcd_pkg

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
   input  logic [3:0] d,
   output logic [3:0] q_c
);

   // Add-3 correction, pure combinational
   always_comb begin
      q_c = d;
      if (d >= 4'd5) q_c = d + 4'd3;
   end

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Optional feature: define BCD_SIGNED_INPUT_EN to treat bin_in as two's
// complement; the magnitude is converted and the sign reported on neg_out.
module bin_to_bcd
   import bin_to_bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  neg_out
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_nxt;
   logic [BCD_W-1:0]   scratch, scratch_nxt;
   logic [BCD_W-1:0]   bcd_adj_c, scratch_shl_c;
   logic [BCD_W-1:0]   bcd_nxt;
   logic [WIDTH-1:0]   operand, operand_nxt;
   logic [WIDTH-1:0]   mag_c;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               done_nxt;
   logic               last_bit_c;

`ifdef BCD_SIGNED_INPUT_EN
   logic neg_lat, neg_lat_nxt;
   logic neg_q, neg_nxt;

   // Magnitude of the two's complement input; the most-negative value wraps to itself,
   // which read as unsigned is exactly its magnitude
   assign mag_c   = bin_in[WIDTH-1] ? WIDTH'(-bin_in) : bin_in;
   assign neg_out = neg_q;
`else
   assign mag_c   = bin_in;
   assign neg_out = 1'b0;
`endif

   // One correction cell per BCD digit of the scratch register
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d   (scratch[4*g +: 4]),
         .q_c (bcd_adj_c[4*g +: 4])
      );
   end

   assign scratch_shl_c = (bcd_adj_c << 1) | BCD_W'(operand[WIDTH-1]);
   assign last_bit_c    = (cnt == CNT_W'(1));
   assign busy          = (state == SHIFT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; clear aborts any conversion
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)      state_nxt = SHIFT;
            SHIFT:   if (last_bit_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      scratch_nxt = scratch;
      operand_nxt = operand;
      cnt_nxt     = cnt;
      bcd_nxt     = bcd_out;
      done_nxt    = 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
      neg_lat_nxt = neg_lat;
      neg_nxt     = neg_q;
`endif
      if (clr) begin
         scratch_nxt = '0;
         operand_nxt = '0;
         cnt_nxt     = '0;
         bcd_nxt     = '0;
`ifdef BCD_SIGNED_INPUT_EN
         neg_lat_nxt = 1'b0;
         neg_nxt     = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  operand_nxt = mag_c;
                  scratch_nxt = '0;
                  cnt_nxt     = CNT_W'(WIDTH);
`ifdef BCD_SIGNED_INPUT_EN
                  neg_lat_nxt = bin_in[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               scratch_nxt = scratch_shl_c;
               operand_nxt = operand << 1;
               cnt_nxt     = cnt - CNT_W'(1);
               if (last_bit_c) begin
                  bcd_nxt  = scratch_shl_c;
                  done_nxt = 1'b1;
`ifdef BCD_SIGNED_INPUT_EN
                  neg_nxt  = neg_lat;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         scratch <= '0;
         operand <= '0;
         cnt     <= '0;
         bcd_out <= '0;
         done    <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
         neg_lat <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         scratch <= scratch_nxt;
         operand <= operand_nxt;
         cnt     <= cnt_nxt;
         bcd_out <= bcd_nxt;
         done    <= done_nxt;
`ifdef BCD_SIGNED_INPUT_EN
         neg_lat <= neg_lat_nxt;
         neg_q   <= neg_nxt;
`endif
      end
   end

endmodule : bin_to_bcd
